// File: rtl/sort_pkg.sv
// Shared types and width helpers for the sort stream checker.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OUT    = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int sum_w(input int w, input int size);
    return w + clog2(size);
  endfunction

endpackage

// File: rtl/stream_accumulator.sv
// Count / sum / xor accumulator for one side of the sorter.
module stream_accumulator
  import sort_pkg::*;
#(
  parameter int W    = 12,
  parameter int SIZE = 1024,
  parameter int CW   = clog2(SIZE + 2),
  parameter int SW   = sum_w(W, SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [W-1:0]  din_i,
  output logic [CW-1:0] cnt_o,
  output logic [SW-1:0] sum_o,
  output logic [W-1:0]  xor_o
);

  localparam logic [CW-1:0] CMAX = CW'(SIZE + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  xor_q, xor_d;

  // A clear and a new sample in the same cycle start a fresh frame
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    sum_d = clr_i ? '0 : sum_q;
    xor_d = clr_i ? '0 : xor_q;
    if (en_i) begin
      if (cnt_d != CMAX) cnt_d = cnt_d + 1'b1;
      sum_d = sum_d + SW'(din_i);
      xor_d = xor_d ^ din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
      xor_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      xor_q <= xor_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sum_o = sum_q;
  assign xor_o = xor_q;

endmodule

// File: rtl/sort_stream_checker.sv
// Checks a sorter's output frames against its input frames.
module sort_stream_checker
  import sort_pkg::*;
#(
  parameter int SIZE  = 1024,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             active_input,
  input  logic [WIDTH-1:0] q,
  input  logic             active_output,
  output logic             done,
  output logic             pass,
  output logic             err_order,
  output logic             err_count,
  output logic             err_sum,
  output logic             err_xor,
  output logic [15:0]      frames
);

  localparam int CW = clog2(SIZE + 2);
  localparam int SW = sum_w(WIDTH, SIZE);
  localparam logic [CW-1:0] CSIZE = CW'(SIZE);

  state_e state_q, state_d;
  logic   report;

  logic          in_run_q;
  logic          in_end;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [SW-1:0] in_sum, out_sum;
  logic [WIDTH-1:0] in_xor, out_xor;

  logic [CW-1:0]    snap_cnt_q;
  logic [SW-1:0]    snap_sum_q;
  logic [WIDTH-1:0] snap_xor_q;
  logic             snap_vld_q;

  logic [WIDTH-1:0] prev_q;
  logic             ord_q, ord_d;

  logic e_ord, e_cnt, e_sum, e_xor;
  logic done_q, pass_q;
  logic eo_q, ec_q, es_q, ex_q;
  logic [15:0] frames_q;

  assign in_end = in_run_q & ~active_input;
  assign report = (state_q == ST_REPORT);

  stream_accumulator #(
    .W    (WIDTH),
    .SIZE (SIZE)
  ) u_in_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (in_end),
    .en_i  (active_input),
    .din_i (d),
    .cnt_o (in_cnt),
    .sum_o (in_sum),
    .xor_o (in_xor)
  );

  stream_accumulator #(
    .W    (WIDTH),
    .SIZE (SIZE)
  ) u_out_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (report),
    .en_i  (active_output),
    .din_i (q),
    .cnt_o (out_cnt),
    .sum_o (out_sum),
    .xor_o (out_xor)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (active_output) state_d = ST_OUT;
      ST_OUT:    if (!active_output) state_d = ST_REPORT;
      ST_REPORT: state_d = active_output ? ST_OUT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Only samples after the first one in a frame are order-checked
  always_comb begin
    ord_d = report ? 1'b0 : ord_q;
    if (active_output && state_q == ST_OUT && q < prev_q)
      ord_d = 1'b1;
  end

  always_comb begin
    e_ord = ord_q;
    e_cnt = (out_cnt != CSIZE) | (snap_cnt_q != CSIZE) | ~snap_vld_q;
    e_sum = ~snap_vld_q | (out_sum != snap_sum_q);
    e_xor = ~snap_vld_q | (out_xor != snap_xor_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      in_run_q <= 1'b0;
      prev_q   <= '0;
      ord_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_run_q <= active_input;
      ord_q    <= ord_d;
      if (active_output) prev_q <= q;
    end
  end

  // A frame end coinciding with REPORT replaces the snapshot just used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_cnt_q <= '0;
      snap_sum_q <= '0;
      snap_xor_q <= '0;
      snap_vld_q <= 1'b0;
    end else if (in_end) begin
      snap_cnt_q <= in_cnt;
      snap_sum_q <= in_sum;
      snap_xor_q <= in_xor;
      snap_vld_q <= 1'b1;
    end else if (report) begin
      snap_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      eo_q     <= 1'b0;
      ec_q     <= 1'b0;
      es_q     <= 1'b0;
      ex_q     <= 1'b0;
      frames_q <= '0;
    end else begin
      done_q <= report;
      if (report) begin
        eo_q     <= e_ord;
        ec_q     <= e_cnt;
        es_q     <= e_sum;
        ex_q     <= e_xor;
        pass_q   <= ~(e_ord | e_cnt | e_sum | e_xor);
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign err_order = eo_q;
  assign err_count = ec_q;
  assign err_sum   = es_q;
  assign err_xor   = ex_q;
  assign frames    = frames_q;

endmodule

// File: tb/tb_sort_stream_checker.sv
// Directed bench with a frame-level reference model.
module tb_sort_stream_checker;

  typedef int arr_t[8];

  logic        clk;
  logic        rst_n;
  logic [11:0] din;
  logic        active_input;
  logic [11:0] qin;
  logic        active_output;
  logic        done, pass;
  logic        err_order, err_count, err_sum, err_xor;
  logic [15:0] frames;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  sort_stream_checker #(
    .SIZE  (4),
    .WIDTH (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .d             (din),
    .active_input  (active_input),
    .q             (qin),
    .active_output (active_output),
    .done          (done),
    .pass          (pass),
    .err_order     (err_order),
    .err_count     (err_count),
    .err_sum       (err_sum),
    .err_xor       (err_xor),
    .frames        (frames)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: frames as queues, verdict one edge after frame end
  int  inq[$];
  int  outq[$];
  int  snap[$];
  int  pf[$];
  bit  snap_ok, pend;
  bit  e_done, e_pass, e_eo, e_ec, e_es, e_ex;
  int  e_frames;
  int  si, so, xi, xo;
  bit  ord;

  initial begin
    e_done = 0; e_pass = 0; e_eo = 0; e_ec = 0;
    e_es = 0; e_ex = 0; e_frames = 0;
    snap_ok = 0; pend = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        inq.delete(); outq.delete();
        snap.delete(); pf.delete();
        snap_ok = 0; pend = 0;
        e_done = 0; e_pass = 0; e_eo = 0; e_ec = 0;
        e_es = 0; e_ex = 0; e_frames = 0;
      end else begin
        e_done = 0;
        if (pend) begin
          si = 0; so = 0; xi = 0; xo = 0; ord = 0;
          foreach (pf[i]) begin
            so += pf[i];
            xo ^= pf[i];
            if (i > 0 && pf[i] < pf[i-1]) ord = 1;
          end
          foreach (snap[i]) begin
            si += snap[i];
            xi ^= snap[i];
          end
          e_eo = ord;
          e_ec = pf.size() != 4 || snap.size() != 4 || !snap_ok;
          e_es = !snap_ok || si != so;
          e_ex = !snap_ok || xi != xo;
          e_pass = !(e_eo || e_ec || e_es || e_ex);
          e_done = 1;
          e_frames = (e_frames + 1) & 16'hffff;
          snap_ok = 0;
          pend = 0;
        end
        if (active_input) inq.push_back(int'(din));
        else if (inq.size() > 0) begin
          snap = inq;
          snap_ok = 1;
          inq.delete();
        end
        if (active_output) outq.push_back(int'(qin));
        else if (outq.size() > 0) begin
          pf = outq;
          pend = 1;
          outq.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle", {done, pass, err_order, err_count,
                    err_sum, err_xor, frames},
          {e_done, e_pass, e_eo, e_ec, e_es, e_ex,
           e_frames[15:0]});
    end
  end

  task automatic cyc(input bit ai, input int dv,
                     input bit ao, input int qv);
    active_input  = ai;
    din           = dv[11:0];
    active_output = ao;
    qin           = qv[11:0];
    @(posedge clk);
    #1;
  endtask

  task automatic send_in(input int n, input arr_t a);
    for (int i = 0; i < n; i++) cyc(1, a[i], 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic send_out(input int n, input arr_t a);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, a[i]);
    active_output = 0;
    active_input  = 0;
  endtask

  task automatic wait_done(input string nm, input int lat);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
    end
    chk(nm, seen ? n : -1, lat);
  endtask

  task automatic verdict(input string nm, input int p, input int eo,
                         input int ec, input int es, input int ex,
                         input int fr);
    chk({nm, "_pass"}, pass, p);
    chk({nm, "_eord"}, err_order, eo);
    chk({nm, "_ecnt"}, err_count, ec);
    chk({nm, "_esum"}, err_sum, es);
    chk({nm, "_exor"}, err_xor, ex);
    chk({nm, "_frames"}, frames, fr);
    chk({nm, "_model"}, e_pass, p);
  endtask

  arr_t din0 = '{7, 3, 9, 3, 0, 0, 0, 0};

  initial begin
    rst_n = 0;
    active_input = 0; din = 0;
    active_output = 0; qin = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_errs", {err_order, err_count, err_sum, err_xor}, 0);
    chk("rst_frames", frames, 0);
    rst_n = 1;
    chk_en = 1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    send_in(4, din0);
    send_out(4, '{3, 3, 7, 9, 0, 0, 0, 0});
    wait_done("t1_lat", 2);
    verdict("t1", 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    send_in(4, din0);
    send_out(4, '{3, 7, 3, 9, 0, 0, 0, 0});
    wait_done("t2_lat", 2);
    verdict("t2", 0, 1, 0, 0, 0, 2);
    cyc(0, 0, 0, 0);

    send_in(4, din0);
    send_out(4, '{3, 3, 7, 8, 0, 0, 0, 0});
    wait_done("t3_lat", 2);
    verdict("t3", 0, 0, 0, 1, 1, 3);
    cyc(0, 0, 0, 0);

    send_out(3, '{1, 2, 3, 0, 0, 0, 0, 0});
    wait_done("t4_lat", 2);
    verdict("t4", 0, 0, 1, 1, 1, 4);
    cyc(0, 0, 0, 0);

    send_in(4, din0);
    send_out(5, '{3, 3, 7, 9, 9, 0, 0, 0});
    wait_done("t5_lat", 2);
    chk("t5_ecnt", err_count, 1);
    chk("t5_pass", pass, 0);
    chk("t5_frames", frames, 5);
    cyc(0, 0, 0, 0);

    send_in(4, din0);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 3);
    rst_n = 0;
    #1;
    chk("t6_async", {done, pass, err_order, err_count,
                     err_sum, err_xor, frames}, 0);
    active_output = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(0, 0, 0, 0);
    send_in(4, din0);
    send_out(4, '{3, 3, 7, 9, 0, 0, 0, 0});
    wait_done("t6_lat", 2);
    verdict("t6", 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    send_in(4, '{1, 2, 3, 4, 0, 0, 0, 0});
    cyc(0, 0, 1, 1);
    cyc(1, 5, 1, 2);
    cyc(1, 6, 1, 3);
    cyc(1, 7, 1, 4);
    cyc(1, 8, 0, 0);
    active_input = 0;
    wait_done("t7a_lat", 1);
    verdict("t7a", 1, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0);
    send_out(4, '{5, 6, 7, 8, 0, 0, 0, 0});
    wait_done("t7b_lat", 2);
    verdict("t7b", 1, 0, 0, 0, 0, 3);

    repeat (3) cyc(0, 0, 0, 0);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
